// File: rtl/dap_usb_transmitter.sv
// -----------------------------------------------------------------------------
// dap_usb_transmitter
//
// IN-direction half of the DAP USB bridge. DAP response bytes arrive on an
// AXI-Stream slave. They are stored in a byte FIFO, and a small queue records
// the length of each committed frame. Each queued frame is offered to the USB
// device controller's endpoint TX interface as one USB packet. When the host
// does not acknowledge a packet, the controller retries it: the read pointer
// is rewound to the packet start and the bytes are sent again. FIFO space is
// released only when the host acknowledges the packet (usb_txpktfin), so the
// bytes of a retry are never overwritten.
//
// Parameters
//   DEPTH_LOG2  data FIFO depth = 2**DEPTH_LOG2 bytes
//   PKTQ_LOG2   length-queue depth = 2**PKTQ_LOG2 packets
//   MAX_PKT     largest USB packet; a frame that reaches MAX_PKT bytes is
//               committed as a packet before its tlast arrives
//   ENDPT       endpoint number served by this block
//
// Optional feature
//   DAP_USB_TX_ZLP_EN  when defined, a response of exactly MAX_PKT bytes that
//                      ends with tlast is followed by a zero-length packet.
//                      When undefined, no zero-length packet is produced.
//
// Ports
//   clk, resetn                 clock and asynchronous active-low reset
//   axis_tvaild/tdata/tlast     AXI-Stream input beat
//   axis_tready                 AXI-Stream input accept
//   usb_endpt                   endpoint currently selected by the controller
//   usb_txact                   controller is transmitting an IN packet
//   usb_txpop                   controller consumed usb_txdat this cycle
//   usb_txpktfin                one-cycle pulse: host ACKed the packet
//   usb_txdat                   current byte (first-word fall-through)
//   usb_txlen                   length of the head packet (0 if none queued)
//   usb_txcork                  1 = nothing ready, so the controller NAKs
//   fifo_full, fifo_empty       data FIFO status, based on the retired pointer
// -----------------------------------------------------------------------------
module dap_usb_transmitter #(
  parameter int DEPTH_LOG2 = 9,
  parameter int PKTQ_LOG2  = 2,
  parameter int MAX_PKT    = 512,
  parameter int ENDPT      = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        axis_tvaild,
  input  logic [7:0]  axis_tdata,
  input  logic        axis_tlast,
  output logic        axis_tready,
  input  logic [3:0]  usb_endpt,
  input  logic        usb_txact,
  input  logic        usb_txpop,
  input  logic        usb_txpktfin,
  output logic [7:0]  usb_txdat,
  output logic [11:0] usb_txlen,
  output logic        usb_txcork,
  output logic        fifo_full,
  output logic        fifo_empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PKTQ  = 1 << PKTQ_LOG2;
  localparam int PTR_W = DEPTH_LOG2 + 1;  // one extra bit separates full from empty
  localparam int QP_W  = PKTQ_LOG2 + 1;

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [QP_W-1:0]  QP_ONE  = QP_W'(1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READY = 2'd1;
  localparam logic [1:0] ST_SEND  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [7:0]       mem  [DEPTH];
  logic [11:0]      lenq [PKTQ];

  logic [PTR_W-1:0] wr_ptr;   // next byte written
  logic [PTR_W-1:0] rd_ptr;   // next byte shown to the controller
  logic [PTR_W-1:0] ret_ptr;  // first byte not yet ACKed by the host
  logic [PTR_W-1:0] mark;     // start of the packet being sent; target of a rewind
  logic [QP_W-1:0]  q_wr;
  logic [QP_W-1:0]  q_rd;
  logic [11:0]      cnt;      // bytes accepted in the current frame
  logic [1:0]       state;
  logic             ready_en; // holds axis_tready low for the first cycle after reset

  // ---------------------------------------------------------------------------
  // Status
  // ---------------------------------------------------------------------------
  logic q_empty, q_full;

  assign fifo_empty = (wr_ptr == ret_ptr);
  assign fifo_full  = (wr_ptr[PTR_W-1] != ret_ptr[PTR_W-1]) &&
                      (wr_ptr[PTR_W-2:0] == ret_ptr[PTR_W-2:0]);
  assign q_empty    = (q_wr == q_rd);
  assign q_full     = (q_wr[QP_W-1] != q_rd[QP_W-1]) &&
                      (q_wr[QP_W-2:0] == q_rd[QP_W-2:0]);

  // ---------------------------------------------------------------------------
  // Write side
  // ---------------------------------------------------------------------------
  logic [11:0] cnt_next;
  logic        at_max, commit_cond, wr_fire, commit;
  logic        zlp_pending, zlp_push, q_push;
  logic [11:0] q_push_len;

  assign cnt_next    = cnt + 12'd1;
  assign at_max      = (cnt_next == 12'(MAX_PKT));
  assign commit_cond = axis_tlast | at_max;
  // A beat that would commit is held off while the length queue is full. A
  // pending zero-length packet also holds the input off, so at most one entry
  // is pushed into the length queue per cycle.
  assign axis_tready = ready_en & ~fifo_full & ~zlp_pending & ~(q_full & commit_cond);
  assign wr_fire     = axis_tvaild & axis_tready;
  assign commit      = wr_fire & commit_cond;
  assign q_push      = commit | zlp_push;
  assign q_push_len  = zlp_push ? 12'd0 : cnt_next;

`ifdef DAP_USB_TX_ZLP_EN
  // A MAX_PKT-byte response that ends with tlast needs a zero-length packet so
  // the host can see where the transfer ends. It is queued one cycle later.
  assign zlp_push = zlp_pending & ~q_full;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      zlp_pending <= 1'b0;
    end else if (commit & axis_tlast & at_max) begin
      zlp_pending <= 1'b1;
    end else if (zlp_push) begin
      zlp_pending <= 1'b0;
    end
  end
`else
  assign zlp_pending = 1'b0;
  assign zlp_push    = 1'b0;
`endif

  // NOTE: storage arrays have no reset. Every read is gated by a pointer
  // comparison, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr[PTR_W-2:0]] <= axis_tdata;
    if (q_push)  lenq[q_wr[QP_W-2:0]]   <= q_push_len;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before the clock edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready_en <= 1'b0;
      wr_ptr   <= '0;
      cnt      <= '0;
      q_wr     <= '0;
    end else begin
      ready_en <= 1'b1;
      if (wr_fire) begin
        wr_ptr <= wr_ptr + PTR_ONE;
        cnt    <= commit ? 12'd0 : cnt_next;
      end
      if (q_push) q_wr <= q_wr + QP_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Read side
  // ---------------------------------------------------------------------------
  logic             endpt_sel, pop_ok, q_pop;
  logic [11:0]      head_len;
  logic [PTR_W-1:0] sent, retire;

  assign endpt_sel = (usb_endpt == 4'(ENDPT));
  assign head_len  = lenq[q_rd[QP_W-2:0]];
  assign sent      = rd_ptr - mark;
  assign retire    = mark + PTR_W'(head_len);
  // Pops after the whole head packet has been shown are ignored, so rd_ptr
  // never moves into the next packet.
  assign pop_ok    = endpt_sel & (state == ST_SEND) & usb_txpop & (12'(sent) < head_len);
  assign q_pop     = endpt_sel & (state == ST_DONE) & usb_txpktfin;

  assign usb_txcork = (state == ST_IDLE);
  assign usb_txlen  = q_empty ? 12'd0 : head_len;
  assign usb_txdat  = (rd_ptr == wr_ptr) ? 8'd0 : mem[rd_ptr[PTR_W-2:0]];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      rd_ptr  <= '0;
      ret_ptr <= '0;
      mark    <= '0;
      q_rd    <= '0;
    end else if (endpt_sel) begin
      case (state)
        ST_IDLE: begin
          if (!q_empty) state <= ST_READY;
        end
        ST_READY: begin
          mark <= rd_ptr;
          if (usb_txact) state <= ST_SEND;
        end
        ST_SEND: begin
          if (pop_ok)     rd_ptr <= rd_ptr + PTR_ONE;
          if (!usb_txact) state  <= ST_DONE;
        end
        default: begin  // ST_DONE
          if (q_pop) begin
            // The ACK retires the whole packet. Pops that were skipped do not
            // leave bytes behind.
            q_rd    <= q_rd + QP_ONE;
            ret_ptr <= retire;
            rd_ptr  <= retire;
            state   <= ST_IDLE;
          end else if (usb_txact) begin
            // The controller starts a retry without an ACK: send the packet again.
            rd_ptr <= mark;
            state  <= ST_SEND;
          end
        end
      endcase
    end
  end

endmodule
